// File: rtl/skor_kontrol.sv
// Round state machine, BCD score and lives keeper for the brick game.
// Define SKOR_HIGH_SCORE_EN to build the high-score registers; otherwise hs_* read 0.
module skor_kontrol #(
    parameter int LIVES_INIT   = 3,
    parameter int BRICKS_TOTAL = 40,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       brick_hit,
    input  logic       ball_miss,
    input  logic       frame_tick,
    output logic [3:0] skor_birler,
    output logic [3:0] skor_onlar,
    output logic [3:0] hs_birler,
    output logic [3:0] hs_onlar,
    output logic [1:0] lives,
    output logic       play_en,
    output logic       ball_reset,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

    state_t     r_state;
    logic       r_start_q;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_bricks_left;
    logic [3:0] r_birler;
    logic [3:0] r_onlar;
    logic [1:0] r_lives;
    logic       r_play_en;
    logic       r_ball_reset;

    logic       w_start_rise;
    logic       w_serve_done;
    logic       w_last_brick;
    logic [7:0] w_bcd_next;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
        if (tens == 4'd9 && ones == 4'd9)
            return {tens, ones};
        else if (ones == 4'd9)
            return {4'(tens + 4'd1), 4'd0};
        else
            return {tens, 4'(ones + 4'd1)};
    endfunction

    assign w_start_rise = start & ~r_start_q;
    assign w_serve_done = (r_frame_cnt == 8'(SERVE_FRAMES - 1));
    assign w_last_brick = (r_bricks_left == 8'd1);
    assign w_bcd_next   = bcd_inc(r_onlar, r_birler);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_start_q     <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_bricks_left <= 8'd0;
            r_birler      <= 4'd0;
            r_onlar       <= 4'd0;
            r_lives       <= 2'd0;
            r_play_en     <= 1'b0;
            r_ball_reset  <= 1'b0;
        end else begin
            r_start_q <= start;
            case (r_state)
                S_IDLE, S_OVER, S_WIN: begin
                    if (w_start_rise) begin
                        r_birler      <= 4'd0;
                        r_onlar       <= 4'd0;
                        r_lives       <= 2'(LIVES_INIT);
                        r_bricks_left <= 8'(BRICKS_TOTAL);
                        r_frame_cnt   <= 8'd0;
                        r_state       <= S_SERVE;
                        r_ball_reset  <= 1'b1;
                        r_play_en     <= 1'b0;
                    end
                end
                S_SERVE: begin
                    if (frame_tick) begin
                        if (w_serve_done) begin
                            r_frame_cnt  <= 8'd0;
                            r_state      <= S_PLAY;
                            r_play_en    <= 1'b1;
                            r_ball_reset <= 1'b0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (brick_hit) begin
                        {r_onlar, r_birler} <= w_bcd_next;
                        r_bricks_left       <= r_bricks_left - 8'd1;
                    end
                    // Clearing the last brick takes priority over a simultaneous miss.
                    if (brick_hit && w_last_brick) begin
                        r_state   <= S_WIN;
                        r_play_en <= 1'b0;
                    end else if (ball_miss) begin
                        r_play_en <= 1'b0;
                        if (r_lives == 2'd1) begin
                            r_lives <= 2'd0;
                            r_state <= S_OVER;
                        end else begin
                            r_lives      <= r_lives - 2'd1;
                            r_state      <= S_SERVE;
                            r_frame_cnt  <= 8'd0;
                            r_ball_reset <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_play_en    <= 1'b0;
                    r_ball_reset <= 1'b0;
                end
            endcase
        end
    end

`ifdef SKOR_HIGH_SCORE_EN
    logic [3:0] r_hs_birler;
    logic [3:0] r_hs_onlar;
    logic       r_was_end;
    logic       w_is_end;

    assign w_is_end = (r_state == S_OVER) || (r_state == S_WIN);

    // Compare on the first cycle spent in OVER/WIN; the score is final by then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_was_end   <= 1'b0;
            r_hs_birler <= 4'd0;
            r_hs_onlar  <= 4'd0;
        end else begin
            r_was_end <= w_is_end;
            if (w_is_end && !r_was_end &&
                ({r_onlar, r_birler} > {r_hs_onlar, r_hs_birler})) begin
                r_hs_onlar  <= r_onlar;
                r_hs_birler <= r_birler;
            end
        end
    end

    assign hs_birler = r_hs_birler;
    assign hs_onlar  = r_hs_onlar;
`else
    assign hs_birler = 4'd0;
    assign hs_onlar  = 4'd0;
`endif

    assign skor_birler = r_birler;
    assign skor_onlar  = r_onlar;
    assign lives       = r_lives;
    assign play_en     = r_play_en;
    assign ball_reset  = r_ball_reset;
    assign state       = r_state;

endmodule

// File: tb/tb_skor_kontrol.sv
// Directed bench for skor_kontrol: two instances (120 and 5 bricks) share stimulus,
// each tracked by an integer-level game model, plus literal checkpoints.
module tb_skor_kontrol;

`ifdef SKOR_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic brick_hit = 1'b0;
    logic ball_miss = 1'b0;
    logic frame_tick = 1'b0;

    always #5 clk = ~clk;

    logic [3:0] a_b, a_o, a_hb, a_ho;
    logic [1:0] a_l;
    logic       a_pe, a_br;
    logic [2:0] a_st;
    logic [3:0] b_b, b_o, b_hb, b_ho;
    logic [1:0] b_l;
    logic       b_pe, b_br;
    logic [2:0] b_st;

    skor_kontrol #(.LIVES_INIT(3), .BRICKS_TOTAL(120), .SERVE_FRAMES(60)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .brick_hit(brick_hit),
        .ball_miss(ball_miss), .frame_tick(frame_tick),
        .skor_birler(a_b), .skor_onlar(a_o), .hs_birler(a_hb), .hs_onlar(a_ho),
        .lives(a_l), .play_en(a_pe), .ball_reset(a_br), .state(a_st));

    skor_kontrol #(.LIVES_INIT(3), .BRICKS_TOTAL(5), .SERVE_FRAMES(60)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .brick_hit(brick_hit),
        .ball_miss(ball_miss), .frame_tick(frame_tick),
        .skor_birler(b_b), .skor_onlar(b_o), .hs_birler(b_hb), .hs_onlar(b_ho),
        .lives(b_l), .play_en(b_pe), .ball_reset(b_br), .state(b_st));

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    typedef struct {
        int st;
        int score;
        int lives;
        int bricks;
        int frames;
        int hs;
        bit sq;
        bit hs_pend;
    } mdl_t;

    mdl_t ma, mb;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Game rules on plain integers: score 0..99, lives counted down, bricks counted down.
    function automatic mdl_t step(input mdl_t m, input int btot, input int sfr,
                                  input bit s, input bit h, input bit mi, input bit t);
        mdl_t n;
        bit rise;
        n = m;
        rise = s && !m.sq;
        n.sq = s;
        n.hs_pend = 1'b0;
        if (HS_EN && m.hs_pend && m.score > m.hs) n.hs = m.score;
        case (m.st)
            0, 3, 4: if (rise) begin
                n.st = 1; n.score = 0; n.lives = 3; n.bricks = btot; n.frames = 0;
            end
            1: if (t) begin
                if (m.frames + 1 >= sfr) begin n.frames = 0; n.st = 2; end
                else n.frames = m.frames + 1;
            end
            2: begin
                if (h) begin
                    n.score = (m.score < 99) ? m.score + 1 : 99;
                    n.bricks = m.bricks - 1;
                end
                if (h && n.bricks == 0) begin
                    n.st = 4; n.hs_pend = 1'b1;
                end else if (mi) begin
                    n.lives = m.lives - 1;
                    if (n.lives == 0) begin n.st = 3; n.hs_pend = 1'b1; end
                    else begin n.st = 1; n.frames = 0; end
                end
            end
            default: n.st = 0;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= step(ma, 120, 60, start, brick_hit, ball_miss, frame_tick);
            mb <= step(mb, 5, 60, start, brick_hit, ball_miss, frame_tick);
        end
    end

    task automatic cmp_dut(input string tag, input mdl_t m,
                           input logic [3:0] b, input logic [3:0] o,
                           input logic [3:0] hb, input logic [3:0] ho,
                           input logic [1:0] l, input logic pe, input logic br,
                           input logic [2:0] st);
        check({tag, ".state"}, int'(st), m.st);
        check({tag, ".birler"}, int'(b), m.score % 10);
        check({tag, ".onlar"}, int'(o), m.score / 10);
        check({tag, ".lives"}, int'(l), m.lives);
        check({tag, ".play_en"}, int'(pe), (m.st == 2) ? 1 : 0);
        check({tag, ".ball_reset"}, int'(br), (m.st == 1) ? 1 : 0);
        check({tag, ".hs_birler"}, int'(hb), m.hs % 10);
        check({tag, ".hs_onlar"}, int'(ho), m.hs / 10);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_dut("A", ma, a_b, a_o, a_hb, a_ho, a_l, a_pe, a_br, a_st);
            cmp_dut("B", mb, b_b, b_o, b_hb, b_ho, b_l, b_pe, b_br, b_st);
        end
    end

    task automatic drive(input bit s, input bit h, input bit m, input bit t);
        start = s;
        brick_hit = h;
        ball_miss = m;
        frame_tick = t;
        @(negedge clk);
    endtask

    task automatic serve();
        repeat (60) drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst.state", int'(a_st), 0);
        check("rst.lives", int'(a_l), 0);
        check("rst.score", int'({a_o, a_b}), 0);
        check("rst.outs", int'({a_pe, a_br}), 0);
        reset_n = 1'b1;
        cmp_en = 1'b1;

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("start.state", int'(a_st), 1);
        check("start.lives", int'(a_l), 3);
        check("start.ball_reset", int'(a_br), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("serve.hit_ignored", int'({a_o, a_b}), 0);
        serve();
        check("play.state", int'(a_st), 2);
        check("play.play_en", int'(a_pe), 1);

        repeat (12) drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("hit12.onlar", int'(a_o), 1);
        check("hit12.birler", int'(a_b), 2);
        repeat (9) drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("hit21.onlar", int'(a_o), 2);
        check("hit21.birler", int'(a_b), 1);

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("play.start_ignored", int'(a_st), 2);

        repeat (84) drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("sat.score", int'({a_o, a_b}), 8'h99);
        check("sat.state", int'(a_st), 2);

        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("miss1.lives", int'(a_l), 2);
        check("miss1.state", int'(a_st), 1);
        serve();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("miss2.lives", int'(a_l), 1);
        serve();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("miss3.lives", int'(a_l), 0);
        check("miss3.state", int'(a_st), 3);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("over.hs", int'({a_ho, a_hb}), HS_EN ? 8'h99 : 0);

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("restart.state", int'(a_st), 1);
        check("restart.score", int'({a_o, a_b}), 0);
        check("restart.hs_kept", int'({a_ho, a_hb}), HS_EN ? 8'h99 : 0);

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.hs_cleared", int'({a_ho, a_hb}), 0);
        reset_n = 1'b1;

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        serve();
        repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check("win.state", int'(b_st), 4);
        check("win.lives", int'(b_l), 3);
        check("win.score", int'({b_o, b_b}), 8'h05);
        check("both.state", int'(a_st), 1);
        check("both.lives", int'(a_l), 2);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("win.hs", int'({b_ho, b_hb}), HS_EN ? 8'h05 : 0);

        serve();
        check("replay.state", int'(a_st), 2);
        #2 reset_n = 1'b0;
        #1;
        check("async.state", int'(a_st), 0);
        check("async.lives", int'(a_l), 0);
        check("async.score", int'({a_o, a_b}), 0);
        check("async.outs", int'({a_pe, a_br}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/skor_kontrol.md
# skor_kontrol

Game-state and score keeper for the brick game. Consumes one-cycle event pulses from the pixel generator (brick hit, ball lost) and a per-frame tick. Runs the round state machine (idle, serve, play, game over, win) and drives BCD score digits `skor_birler`/`skor_onlar`, which feed the 7-segment scan logic in the top level. Also maintains lives and an optional high score.

## Interface
Parameters:
- `LIVES_INIT`, default 3: lives at game start; legal range 1..3.
- `BRICKS_TOTAL`, default 40: bricks per level; legal range 1..255.
- `SERVE_FRAMES`, default 60: frame ticks spent in SERVE before play resumes; legal range 1..255.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `start` in 1: debounced start button, level. Only its rising edge acts.
- `brick_hit` in 1: one-cycle pulse, ball destroyed a brick.
- `ball_miss` in 1: one-cycle pulse, ball passed the paddle.
- `frame_tick` in 1: one-cycle pulse, once per video frame.
- `skor_birler` out 4: score ones digit, BCD 0..9.
- `skor_onlar` out 4: score tens digit, BCD 0..9.
- `hs_birler` out 4: high-score ones digit, BCD.
- `hs_onlar` out 4: high-score tens digit, BCD.
- `lives` out 2: remaining lives.
- `play_en` out 1: high only in PLAY; ball motion is enabled.
- `ball_reset` out 1: high throughout SERVE; the pixel generator re-centres the ball.
- `state` out 3: current state. IDLE=0, SERVE=1, PLAY=2, OVER=3, WIN=4.

## Operation
- Start edge detect:
  - One register holds last cycle's `start`.
  - `start_rise = start & ~start_q`.
- IDLE:
  - All outputs hold.
  - `start_rise` starts a new game: score←00, lives←`LIVES_INIT`, bricks_left←`BRICKS_TOTAL`, frame counter←0, state→SERVE.
- SERVE:
  - Frame counter increments on each `frame_tick`.
  - When the counter reaches `SERVE_FRAMES`, the counter clears and state→PLAY.
  - `brick_hit` and `ball_miss` are ignored.
- PLAY:
  - `brick_hit`: score increments by one in BCD. Ones digit 9→0 carries into the tens digit. Score saturates at 99. bricks_left decrements; if it reaches 0, state→WIN.
  - `ball_miss`: if lives==1, lives←0 and state→OVER. Otherwise lives decrements and state→SERVE with the frame counter cleared.
  - `brick_hit` and `ball_miss` in the same cycle: the hit is scored first. If that hit clears the last brick, WIN wins and the miss is discarded (lives unchanged). Otherwise both apply.
- OVER / WIN:
  - Score and lives hold. `brick_hit` and `ball_miss` are ignored.
  - `start_rise` starts a new game, exactly as from IDLE.
- High score:
  - Updated on the transition into OVER or WIN: if {onlar,birler} > {hs_onlar,hs_birler}, the high score takes the score.
  - The comparison is numeric on the BCD pair: tens digit first, then ones.
  - The high score is never cleared by `start`, only by `reset_n`.
- `start_rise` during SERVE or PLAY is ignored.

## Timing
- All outputs are registered. An input pulse sampled at edge N is reflected on the outputs after edge N.
- A high-score update is visible one cycle after the state changes to OVER or WIN.
- `play_en` and `ball_reset` decode from the state register and change in the same cycle as `state`.
- Reset value of every output: all score and high-score digits 0, `lives`=0, `play_en`=0, `ball_reset`=0, `state`=IDLE. Internal counters and `start_q` are also 0.
- Reset mid-game discards the game, including the high score.
- Widths:
  - bricks_left is 8 bits.
  - The frame counter is 8 bits.
  - Score arithmetic is per-digit 4-bit BCD and never produces a digit above 9.
- `frame_tick` coinciding with the final SERVE count is consumed by the SERVE→PLAY transition. No event is dropped in PLAY on that cycle.

## Configuration
- `SKOR_HIGH_SCORE_EN` defined:
  - High-score registers and the comparator are built.
  - `hs_birler`/`hs_onlar` behave as described above.
- Not defined:
  - No high-score logic is built.
  - `hs_birler`/`hs_onlar` are tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then `start` high → SERVE. After 60 `frame_tick` pulses, `state`=2 and `play_en`=1. Check that `lives`=3 and score=00.
- In PLAY, apply 12 `brick_hit` pulses → `skor_onlar`=1, `skor_birler`=2. Apply 9 more → 21, confirming correct carry across 19→20.
- Set `BRICKS_TOTAL`=120 and apply 105 hits → score saturates at 99 and `state` remains PLAY.
- Apply 3 `ball_miss` pulses with SERVE waits between them → `lives` steps 2, 1, 0 and `state`=3. High score equals the final score (macro defined) or 0 (macro undefined).
- With `BRICKS_TOTAL`=5 and 4 hits done, pulse `brick_hit` and `ball_miss` in the same cycle → `state`=4, `lives` unchanged, score=05.
- Assert `reset_n`=0 mid-PLAY → all outputs return to reset values immediately, asynchronously. A `start` pulse during PLAY is ignored.
